// File: rtl/branch_pred_decoder_pkg.sv
// Shared definitions for the next-PC unit: RV32I opcodes used by the
// front end, prediction policy encodings, JALR wait states, immediate
// decoders and the single PC adder.
package branch_pred_decoder_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int unsigned PRED_MODE_NOT_TAKEN = 0;
  localparam int unsigned PRED_MODE_TAKEN     = 1;
  localparam int unsigned PRED_MODE_DYNAMIC   = 2;

  typedef enum logic {
    JALR_IDLE = 1'b0,
    JALR_WAIT = 1'b1
  } jalr_state_e;

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] u_imm(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

  // 32-bit modulo add; carry-out intentionally dropped.
  function automatic logic [31:0] pc_adder(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/branch_pred_decoder_bht_counter_table.sv
// Direct-mapped table of 2-bit saturating counters.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   rd_idx / rd_cnt        - asynchronous read port
//   upd_valid / upd_idx /
//   upd_taken              - synchronous training port
// A read and an update of the same entry in one cycle returns the old value.
module bht_counter_table #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  CNT_INIT    = 2'b10,
  localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [BHT_ENTRIES];

  assign rd_cnt = cnt[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        cnt[i] <= CNT_INIT;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (cnt[upd_idx] != 2'b11) cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
      end else begin
        if (cnt[upd_idx] != 2'b00) cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_pred_decoder.sv
// Next-PC unit for the fetch/decode front end.
// Policies: static not-taken, static taken, or dynamic (2-bit counter BHT
// trained by the ROB). Holds fetch on a JALR until the ROB redirects.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global hold)
//   _br_rob/_rob_new_pc/_rob_imm            - ROB redirect
//   _rob_upd_valid/_rob_upd_pc/_rob_upd_taken - BHT training
//   _clear                                  - front-end flush
//   _inst_in/_inst_ready_in/_inst_addr      - fetched instruction
//   _stall, _next_pc, _pred_taken           - outputs
module branch_pred_decoder
  import branch_pred_decoder_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  CNT_INIT    = 2'b10,
  parameter int unsigned PRED_MODE   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _br_rob,
  input  logic [31:0] _rob_new_pc,
  input  logic [31:0] _rob_imm,
  input  logic        _rob_upd_valid,
  input  logic [31:0] _rob_upd_pc,
  input  logic        _rob_upd_taken,
  input  logic        _clear,
  input  logic [31:0] _inst_in,
  input  logic        _inst_ready_in,
  input  logic [31:0] _inst_addr,
  output logic        _stall,
  output logic [31:0] _next_pc,
  output logic        _pred_taken
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  jalr_state_e state;
  logic        jalr_pend;
  logic [6:0]  opcode;
  logic        is_branch;
  logic        is_jalr;
  logic        pred_raw;
  logic [31:0] base;
  logic [31:0] offset;

  assign opcode    = _inst_in[6:0];
  assign is_branch = _inst_ready_in && (opcode == OPC_BRANCH);
  assign is_jalr   = _inst_ready_in && (opcode == OPC_JALR);
  assign jalr_pend = (state == JALR_WAIT);

  generate
    if (PRED_MODE == PRED_MODE_DYNAMIC) begin : g_dyn
      logic [1:0] rd_cnt;
      logic       unused_dyn;
      bht_counter_table #(
        .BHT_ENTRIES(BHT_ENTRIES),
        .CNT_INIT   (CNT_INIT)
      ) u_bht (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .rd_idx   (_inst_addr[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .upd_valid(_rob_upd_valid & rdy_in),
        .upd_idx  (_rob_upd_pc[IDX_W+1:2]),
        .upd_taken(_rob_upd_taken)
      );
      assign pred_raw   = rd_cnt[1];
      assign unused_dyn = ^{_rob_upd_pc[31:IDX_W+2], _rob_upd_pc[1:0], rd_cnt[0]};
    end else begin : g_static
      logic unused_static;
      assign pred_raw      = (PRED_MODE == PRED_MODE_TAKEN);
      assign unused_static = ^{_rob_upd_valid, _rob_upd_pc, _rob_upd_taken};
    end
  endgenerate

  assign _pred_taken = is_branch & pred_raw;
  assign _stall      = jalr_pend | (is_jalr & ~_br_rob & ~_clear);

  // Operand select feeding one shared adder; holding the PC adds zero.
  always_comb begin
    base   = _inst_addr;
    offset = 32'd4;
    if (_br_rob) begin
      base   = _rob_new_pc;
      offset = _rob_imm;
    end else if (_clear || !_inst_ready_in || jalr_pend) begin
      offset = '0;
    end else begin
      unique case (opcode)
        OPC_BRANCH: offset = _pred_taken ? b_imm(_inst_in) : 32'd4;
        OPC_JAL:    offset = j_imm(_inst_in);
        OPC_AUIPC:  offset = u_imm(_inst_in);
        default:    offset = 32'd4;
      endcase
    end
  end

  assign _next_pc = pc_adder(base, offset);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= JALR_IDLE;
    end else if (rdy_in) begin
      if (_br_rob || _clear) state <= JALR_IDLE;
      else if (is_jalr)      state <= JALR_WAIT;
    end
  end

endmodule

// File: tb/tb_branch_pred_decoder.sv
module tb_branch_pred_decoder;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam int K_BRANCH = 0, K_JAL = 1, K_JALR = 2, K_AUIPC = 3, K_OTHER = 4;

  typedef struct packed {
    logic [2:0][31:0] pc;
    logic [2:0]       pred;
    logic             stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, rdy = 1'b1, br_rob = 1'b0, upd_v = 1'b0, upd_t = 1'b0;
  logic        clr = 1'b0, ready = 1'b0;
  logic [31:0] new_pc = '0, rob_imm = '0, upd_pc = '0, inst = '0, addr = '0;
  logic [31:0] imm_exp = '0;
  int          kind = K_OTHER;

  logic [31:0] next_pc_o [3];
  logic        stall_o   [3];
  logic        pred_o    [3];

  int    cnt [64];
  bit    pend = 1'b0;
  exp_t  exp_q [$];
  string tag_q [$];
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    branch_pred_decoder #(
      .BHT_ENTRIES(64),
      .CNT_INIT   (2'b10),
      .PRED_MODE  (m)
    ) dut (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .rdy_in        (rdy),
      ._br_rob       (br_rob),
      ._rob_new_pc   (new_pc),
      ._rob_imm      (rob_imm),
      ._rob_upd_valid(upd_v),
      ._rob_upd_pc   (upd_pc),
      ._rob_upd_taken(upd_t),
      ._clear        (clr),
      ._inst_in      (inst),
      ._inst_ready_in(ready),
      ._inst_addr    (addr),
      ._stall        (stall_o[m]),
      ._next_pc      (next_pc_o[m]),
      ._pred_taken   (pred_o[m])
    );
  end

  // Build an instruction carrying a chosen immediate; other fields random.
  task automatic set_inst(input int k, input int imm);
    logic [31:0] r, v;
    logic [6:0]  others [5];
    others = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111};
    r = $urandom;
    v = imm;
    kind = k;
    imm_exp = v;
    case (k)
      K_BRANCH: begin
        r[31] = v[12]; r[30:25] = v[10:5]; r[11:8] = v[4:1]; r[7] = v[11];
        r[6:0] = OPC_BRANCH;
      end
      K_JAL: begin
        r[31] = v[20]; r[30:21] = v[10:1]; r[20] = v[11]; r[19:12] = v[19:12];
        r[6:0] = OPC_JAL;
      end
      K_JALR:  r[6:0] = OPC_JALR;
      K_AUIPC: begin
        r[6:0] = OPC_AUIPC;
        imm_exp = r & 32'hFFFF_F000;
      end
      default: r[6:0] = others[$urandom_range(0, 4)];
    endcase
    inst = r;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1; rdy = 1'b1; br_rob = 1'b0; clr = 1'b0; upd_v = 1'b0; ready = 1'b0;
  endtask

  // Reference model: expected outputs from current state, then advance state.
  task automatic push(input string tag);
    exp_t e;
    bit   is_br, is_jr, taken;
    int   idx;
    if (!rst_n) begin
      pend = 1'b0;
      foreach (cnt[i]) cnt[i] = 2;
    end
    is_br = ready && kind == K_BRANCH;
    is_jr = ready && kind == K_JALR;
    idx = int'((addr / 4) % 64);
    for (int m = 0; m < 3; m++) begin
      taken = (m == 1) || (m == 2 && cnt[idx] >= 2);
      e.pred[m] = is_br && taken;
      if (br_rob)                     e.pc[m] = new_pc + rob_imm;
      else if (clr || !ready || pend) e.pc[m] = addr;
      else if (kind == K_BRANCH)      e.pc[m] = addr + (e.pred[m] ? imm_exp : 32'd4);
      else if (kind == K_JAL || kind == K_AUIPC) e.pc[m] = addr + imm_exp;
      else                            e.pc[m] = addr + 32'd4;
    end
    e.stall = pend || (is_jr && !br_rob && !clr);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst_n && rdy) begin
      if (br_rob || clr) pend = 1'b0;
      else if (is_jr)    pend = 1'b1;
      if (upd_v) begin
        idx = int'((upd_pc / 4) % 64);
        if (upd_t) cnt[idx] = (cnt[idx] < 3) ? cnt[idx] + 1 : 3;
        else       cnt[idx] = (cnt[idx] > 0) ? cnt[idx] - 1 : 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      for (int m = 0; m < 3; m++) begin
        check($sformatf("%s next_pc m%0d", t, m), next_pc_o[m], e.pc[m]);
        check($sformatf("%s pred m%0d", t, m), {31'b0, pred_o[m]}, {31'b0, e.pred[m]});
        check($sformatf("%s stall m%0d", t, m), {31'b0, stall_o[m]}, {31'b0, e.stall});
      end
    end
  end

  task automatic upd(input logic [31:0] pc, input logic t, input string tag);
    begin_cycle();
    upd_v = 1'b1; upd_pc = pc; upd_t = t; addr = 32'h500;
    push(tag);
  endtask

  task automatic br_at(input logic [31:0] a, input int imm, input string tag);
    begin_cycle();
    ready = 1'b1; addr = a; set_inst(K_BRANCH, imm);
    push(tag);
  endtask

  initial begin
    foreach (cnt[i]) cnt[i] = 2;
    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      begin_cycle(); rst_n = 1'b0; addr = 32'h100; push("in_reset");
    end
    br_at(32'h100, 32'h20, "reset_value");
    upd(32'h100, 1'b0, "train_nt1");
    upd(32'h100, 1'b0, "train_nt2");
    br_at(32'h100, 32'h20, "after_nt2");
    upd(32'h100, 1'b0, "train_nt3");
    br_at(32'h100, 32'h20, "sat_low");
    for (int i = 0; i < 3; i++) upd(32'h200, 1'b1, "alias_train");
    br_at(32'h100, 32'h20, "alias_lookup");
    upd(32'h100, 1'b0, "to_weak_taken");
    begin_cycle();
    ready = 1'b1; addr = 32'h100; set_inst(K_BRANCH, 32'h20);
    upd_v = 1'b1; upd_pc = 32'h100; upd_t = 1'b0;
    push("same_cycle");
    br_at(32'h100, 32'h20, "after_same_cycle");
    // JALR stall then redirect
    begin_cycle(); ready = 1'b1; addr = 32'h300; set_inst(K_JALR, 0); push("jalr_issue");
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); addr = 32'h304; push("jalr_idle");
    end
    begin_cycle(); br_rob = 1'b1; new_pc = 32'h400; rob_imm = 32'd8; addr = 32'h304;
    push("jalr_redirect");
    begin_cycle(); addr = 32'h408; push("jalr_released");
    // Static modes and redirect priority
    br_at(32'h100, 32'h20, "static_modes");
    begin_cycle(); ready = 1'b1; addr = 32'h100; set_inst(K_BRANCH, 32'h20);
    br_rob = 1'b1; new_pc = 32'h1000; rob_imm = 32'h40; push("redirect_wins");
    // rdy low freezes JALR capture and training
    begin_cycle(); rdy = 1'b0; ready = 1'b1; addr = 32'h300; set_inst(K_JALR, 0);
    upd_v = 1'b1; upd_pc = 32'h100; upd_t = 1'b1; push("rdy_low");
    br_at(32'h100, 32'h20, "after_rdy_low");
    // Async reset while waiting on a JALR
    begin_cycle(); ready = 1'b1; addr = 32'h300; set_inst(K_JALR, 0); push("jalr_before_rst");
    begin_cycle(); rst_n = 1'b0; addr = 32'h304; push("async_rst");
    begin_cycle(); rst_n = 1'b0; addr = 32'h304; push("rst_hold");
    br_at(32'h100, 32'h20, "cnt_after_rst");
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      begin_cycle();
      rst_n = ($urandom_range(0, 199) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      br_rob = ($urandom_range(0, 11) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      new_pc = $urandom; rob_imm = $urandom;
      upd_v  = $urandom_range(0, 1); upd_t = $urandom_range(0, 1);
      upd_pc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      ready  = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 15) == 0) addr = 32'hFFFF_FF00 | {24'b0, 6'($urandom), 2'b00};
      else addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      r = $urandom_range(0, 99);
      if (r < 35)      set_inst(K_BRANCH, (int'($urandom_range(0, 4095)) - 2048) * 2);
      else if (r < 45) set_inst(K_JAL, (int'($urandom_range(0, 1048575)) - 524288) * 2);
      else if (r < 50) set_inst(K_JALR, 0);
      else if (r < 60) set_inst(K_AUIPC, 0);
      else             set_inst(K_OTHER, 0);
      push("random");
    end
    begin_cycle();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pred_decoder.md
# branch_pred_decoder

Parameterised next-PC unit for the fetch/decode front end. Replaces the fixed "always predict taken" next-PC path with three selectable policies: static not-taken, static taken, and dynamic. The dynamic policy uses a direct-mapped table of 2-bit saturating counters that the ROB trains on branch resolution. The block also holds a latched JALR stall until the ROB redirects, and reports the prediction it made so the ROB can detect mispredicts.

## Interface
Parameters:
- `BHT_ENTRIES`, default 64: number of counters; must be a power of two, at least 2. `IDX_W = log2(BHT_ENTRIES)`.
- `CNT_INIT`, default 2'b10: counter value after reset (weakly taken).
- `PRED_MODE`, default 2: prediction policy. 0 = static not-taken, 1 = static taken, 2 = dynamic.

Ports:
- `clk_in` input 1: system clock. This is the only clock.
- `rst_in` input 1: reset, asynchronous and active-low.
- `rdy_in` input 1: when low, all state holds.
- `_br_rob` input 1: ROB redirect (mispredict or JALR resolution).
- `_rob_new_pc` input 32: redirect base PC.
- `_rob_imm` input 32: redirect offset.
- `_rob_upd_valid` input 1: a branch resolved this cycle.
- `_rob_upd_pc` input 32: PC of the resolved branch.
- `_rob_upd_taken` input 1: actual outcome of the resolved branch.
- `_clear` input 1: front-end flush.
- `_inst_in` input 32: fetched instruction.
- `_inst_ready_in` input 1: `_inst_in` is valid.
- `_inst_addr` input 32: PC of `_inst_in`.
- `_stall` output 1: fetch must hold.
- `_next_pc` output 32: next fetch PC.
- `_pred_taken` output 1: prediction for the current branch; 0 for any non-branch.

## Operation
Immediate decode (RV32I):
- Branch: B-type immediate.
- JAL: J-type immediate.
- AUIPC: `{inst[31:12], 12'b0}`.
- Every other instruction, including JALR: offset 4.

Prediction:
- `PRED_MODE` 0: `_pred_taken` = 0.
- `PRED_MODE` 1: `_pred_taken` = 1.
- `PRED_MODE` 2: `_pred_taken` = `bht[_inst_addr[IDX_W+1:2]][1]`.
- `_pred_taken` is forced to 0 unless the opcode is BRANCH and `_inst_ready_in` is high.

Next-PC selection, in priority order:
1. `_br_rob` = 1: `_next_pc = _rob_new_pc + _rob_imm`.
2. `_clear` = 1, or `_inst_ready_in` = 0, or `jalr_pend` = 1: `_next_pc = _inst_addr`.
3. Branch: `_inst_addr + (_pred_taken ? br_imm : 4)`.
4. JAL or AUIPC: `_inst_addr` plus that opcode's immediate.
5. Anything else: `_inst_addr + 4`.

All additions are 32-bit modulo; the carry-out is discarded.

JALR stall state machine, register `jalr_pend`:
- IDLE to WAIT: a JALR is present (`_inst_ready_in` = 1, opcode JALR), with `_br_rob` = 0, `_clear` = 0 and `rdy_in` = 1.
- WAIT to IDLE: `_br_rob` = 1 or `_clear` = 1. `_br_rob` and `_clear` take priority over a new JALR in the same cycle.
- `_stall` = `jalr_pend`, OR (a JALR is present AND `_br_rob` = 0 AND `_clear` = 0).

BHT training, active only when `PRED_MODE` = 2:
- Trains when `_rob_upd_valid` = 1 and `rdy_in` = 1.
- Index: `_rob_upd_pc[IDX_W+1:2]`.
- Taken increments the counter, saturating at 3. Not-taken decrements it, saturating at 0.
- Training is independent of `_br_rob` and `_clear`; both may occur in the same cycle.
- In modes 0 and 1 the table is not instantiated.

## Timing
- Lookup and `_next_pc` are combinational from inputs and registered state; there is no added latency.
- A counter update becomes visible on the cycle after the update edge.
- When a lookup and an update hit the same index in the same cycle, the lookup returns the old value. There is no bypass.
- Reset is asynchronous. While `rst_in` = 0:
  - all counters = `CNT_INIT`;
  - `jalr_pend` = 0.
- Outputs during reset follow the combinational rules above with `jalr_pend` = 0.
- Deasserting `rst_in` in the middle of an operation discards any pending JALR wait.
- `rdy_in` = 0 freezes counters and `jalr_pend`. The combinational outputs still track their inputs.
- Aliasing: branches whose PCs match in bits `[IDX_W+1:2]` share one counter. This is intended.

## Structure
- Shared defines header holds:
  - opcode constants BRANCH, JALR, JAL, AUIPC;
  - `PRED_MODE` encodings.
- One sub-module, `bht_counter_table`:
  - parameters `BHT_ENTRIES` and `CNT_INIT`;
  - one asynchronous read port, index in, counter out;
  - one synchronous update port: valid, index, taken.
- The `pc_adder` instance is reused for the next-PC sum.

## Test plan
All cases use `BHT_ENTRIES` = 64.
- **Reset value:** mode 2, after reset, branch at 0x100 with imm +0x20 → `_pred_taken` = 1, `_next_pc` = 0x120.
- **Training to not-taken:** mode 2, two updates for pc 0x100 with taken = 0 → next lookup of 0x100 gives `_pred_taken` = 0, `_next_pc` = 0x104. A third not-taken update keeps the counter at 00.
- **Aliasing and same-cycle update:**
  - Train pc 0x200 (index 0, same as 0x100) to 11 → lookup of 0x100 predicts taken.
  - Lookup and update of the same index in one cycle → the lookup returns the old value.
- **JALR stall:** JALR at 0x300 → `_stall` = 1 immediately, and stays 1 for 5 idle cycles. `_br_rob` = 1 with new_pc 0x400 and imm 8 → `_next_pc` = 0x408 in that cycle, and `_stall` = 0 on the next cycle.
- **Static modes and priority:**
  - Mode 0, branch at 0x100 → `_next_pc` = 0x104.
  - Mode 1, same branch → `_next_pc` = 0x120.
  - `_br_rob` and an instruction in the same cycle → the redirect wins.
- **Async reset mid-wait:** drop `rst_in` while `jalr_pend` = 1 → `_stall` clears asynchronously and counters return to 2'b10.
